branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 21 ++
 rtl/branch_predictor_counter.sv | 18 +
 rtl/branch_predictor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: counter encodings and PC step.
package branch_predictor_pkg;

    localparam int PC_INC = 4;

    // Reference encodings for the default 2-bit counter.
    localparam logic [1:0] CNT2_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT2_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT2_WEAK_T    = 2'b10;
    localparam logic [1:0] CNT2_STRONG_T  = 2'b11;

    // Width-generic encodings: weakly taken is MSB set, rest clear.
    function automatic int cnt_weak_taken(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int cnt_strong_taken(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/branch_predictor_counter.sv
// bp_counter: next value of a CNT_W-bit saturating up/down predictor counter.
module bp_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             taken_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i && (cnt_i != '1))
            cnt_o = cnt_i + 1'b1;
        else if (!taken_i && (cnt_i != '0))
            cnt_o = cnt_i - 1'b1;
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters and zero-latency lookup.
// Optional performance counters enabled by macro BP_STATS_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [ADDR_W-1:0] lk_pc,
    input  logic              lk_en,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_weak_taken(CNT_W));

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit;
    logic [CNT_W-1:0] upd_cnt_nxt;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign pred_taken  = lk_hit & cnt_q[lk_idx][CNT_W-1];
    assign pred_target = pred_taken ? tgt_q[lk_idx] : lk_pc + ADDR_W'(PC_INC);

    assign mispredict = upd_valid &
                        ((upd_taken != upd_pred_taken) |
                         (upd_taken & (upd_target != upd_pred_target)));

    bp_counter #(.CNT_W(CNT_W)) u_cnt (
        .cnt_i   (cnt_q[upd_idx]),
        .taken_i (upd_taken),
        .cnt_o   (upd_cnt_nxt)
    );

    // Lookups read the arrays combinationally, so same-cycle updates show next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (clear) begin
            valid_q <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                cnt_q[upd_idx] <= upd_cnt_nxt;
                if (upd_taken)
                    tgt_q[upd_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                tgt_q[upd_idx]   <= upd_target;
                cnt_q[upd_idx]   <= CNT_INIT;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] lookups_q, lookups_d;
    logic [31:0] branches_q, branches_d;
    logic [31:0] mispred_q, mispred_d;

    always_comb begin
        lookups_d  = lookups_q  + {31'd0, lk_en};
        branches_d = branches_q + {31'd0, upd_valid};
        mispred_d  = mispred_q  + {31'd0, mispredict};
    end

    // Stats survive clear; only reset zeroes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q  <= '0;
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            lookups_q  <= lookups_d;
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
        end
    end

    assign stat_lookups  = lookups_q;
    assign stat_branches = branches_q;
    assign stat_mispred  = mispred_q;

    logic unused_bits;
    assign unused_bits = ^{lk_pc[1:0], upd_pc[1:0]};
`else
    assign stat_lookups  = '0;
    assign stat_branches = '0;
    assign stat_mispred  = '0;

    logic unused_bits;
    assign unused_bits = ^{lk_pc[1:0], upd_pc[1:0], lk_en};
`endif

endmodule
